// File: rtl/sd_cmd_pkg.sv
// Shared types and widths for the SD command scheduler and its arbiter.
package sd_cmd_pkg;

    localparam int CMD_IDX_W = 6;
    localparam int CMD_ARG_W = 32;
    localparam int RESP_W    = 128;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_R48  = 2'd1,
        RESP_R136 = 2'd2
    } resp_type_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_CRCERR  = 2'd2
    } resp_status_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_COMPLETE  = 3'd3,
        S_GAP       = 3'd4
    } sched_state_e;

    // The reserved encoding 3 behaves as a 48-bit response.
    function automatic resp_type_e norm_resp_type(input logic [1:0] t);
        if (t == 2'd0) return RESP_NONE;
        if (t == 2'd2) return RESP_R136;
        return RESP_R48;
    endfunction

endpackage

// File: rtl/sd_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when adv_i accepts a grant.
module sd_rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_q]) begin
            gnt_o[ptr_q] = 1'b1;
        end else if (req_i[~ptr_q]) begin
            gnt_o[~ptr_q] = 1'b1;
        end
    end

    // After serving requester 0 favour 1, and vice versa.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (adv_i && (gnt_o != 2'b00)) begin
            ptr_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/sd_cmd_scheduler.sv
// Serialises two requesters onto the SD command path: issue, wait, report, Ncc gap.
// Optional CRC-error retry is enabled by defining SD_CMD_RETRY_EN.
module sd_cmd_scheduler
    import sd_cmd_pkg::*;
#(
    parameter int gRespTimeout = 64,
    parameter int gNccCycles   = 8,
    parameter int gMaxRetries  = 2
) (
    input  logic                      Clk,
    input  logic                      nResetAsync,
    input  logic [1:0]                iReqValid,
    input  logic [1:0][CMD_IDX_W-1:0] iReqIndex,
    input  logic [1:0][CMD_ARG_W-1:0] iReqArg,
    input  logic [1:0][1:0]           iReqRespType,
    output logic [1:0]                oReqGrant,
    output logic [1:0]                oReqDone,
    output logic [1:0]                oRespStatus,
    output logic [RESP_W-1:0]         oRespData,
    output logic                      oCmdValid,
    output logic [CMD_IDX_W-1:0]      oCmdIndex,
    output logic [CMD_ARG_W-1:0]      oCmdArg,
    output logic [1:0]                oCmdExpectResp,
    input  logic                      iCmdAck,
    input  logic                      iRespValid,
    input  logic                      iRespCrcErr,
    input  logic [RESP_W-1:0]         iRespData,
    output logic [2:0]                oDbgState
);

`ifdef SD_CMD_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int CNT_MAX = (gRespTimeout > gNccCycles) ? gRespTimeout : gNccCycles;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(gRespTimeout - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(gNccCycles - 1);

    sched_state_e           state_q;
    logic                   sel_q;
    logic [CMD_IDX_W-1:0]   idx_q;
    logic [CMD_ARG_W-1:0]   arg_q;
    resp_type_e             type_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [3:0]             retry_q;
    logic                   retry_pend_q;
    logic [1:0]             grant_q;
    logic [1:0]             done_q;
    logic                   cmd_valid_q;
    resp_status_e           status_q;
    logic [RESP_W-1:0]      data_q;
    logic [1:0]             arb_gnt;

    sd_rr_arbiter2 u_arb (
        .clk_i  (Clk),
        .rst_ni (nResetAsync),
        .req_i  (iReqValid),
        .adv_i  (state_q == S_IDLE),
        .gnt_o  (arb_gnt)
    );

    // Command handshake: oCmdValid rises with the fields latched and holds them
    // stable until iCmdAck is sampled high; valid drops on the following cycle.
    always_ff @(posedge Clk or negedge nResetAsync) begin
        if (!nResetAsync) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            idx_q        <= '0;
            arg_q        <= '0;
            type_q       <= RESP_NONE;
            cnt_q        <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            cmd_valid_q  <= 1'b0;
            status_q     <= ST_OK;
            data_q       <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        grant_q     <= arb_gnt;
                        sel_q       <= arb_gnt[1];
                        idx_q       <= iReqIndex[arb_gnt[1]];
                        arg_q       <= iReqArg[arb_gnt[1]];
                        type_q      <= norm_resp_type(iReqRespType[arb_gnt[1]]);
                        retry_q     <= '0;
                        cmd_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (iCmdAck) begin
                        cmd_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        if (type_q == RESP_NONE) begin
                            done_q[sel_q] <= 1'b1;
                            status_q      <= ST_OK;
                            data_q        <= '0;
                            state_q       <= S_COMPLETE;
                        end else begin
                            state_q <= S_WAIT_RESP;
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (iRespValid) begin
                        if (RETRY_EN && iRespCrcErr && (int'(retry_q) < gMaxRetries)) begin
                            retry_q      <= retry_q + 4'd1;
                            retry_pend_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= S_GAP;
                        end else begin
                            done_q[sel_q] <= 1'b1;
                            status_q      <= iRespCrcErr ? ST_CRCERR : ST_OK;
                            data_q        <= (type_q == RESP_R136) ? iRespData
                                                                   : {96'd0, iRespData[31:0]};
                            state_q       <= S_COMPLETE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        done_q[sel_q] <= 1'b1;
                        status_q      <= ST_TIMEOUT;
                        data_q        <= '0;
                        state_q       <= S_COMPLETE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_COMPLETE: begin
                    cnt_q   <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        if (retry_pend_q) begin
                            retry_pend_q <= 1'b0;
                            cmd_valid_q  <= 1'b1;
                            state_q      <= S_ISSUE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oReqGrant      = grant_q;
    assign oReqDone       = done_q;
    assign oRespStatus    = status_q;
    assign oRespData      = data_q;
    assign oCmdValid      = cmd_valid_q;
    assign oCmdIndex      = idx_q;
    assign oCmdArg        = arg_q;
    assign oCmdExpectResp = type_q;
    assign oDbgState      = state_q;

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// Directed and randomized checks of sd_cmd_scheduler against a transaction-level model.
module tb_sd_cmd_scheduler;
    import sd_cmd_pkg::*;

    localparam int TIMEOUT     = 64;
    localparam int NCC         = 8;
    localparam int MAX_RETRIES = 2;
`ifdef SD_CMD_RETRY_EN
    localparam int RETRY_EN = 1;
`else
    localparam int RETRY_EN = 0;
`endif

    logic                Clk = 1'b0;
    logic                nResetAsync;
    logic [1:0]          iReqValid;
    logic [1:0][5:0]     iReqIndex;
    logic [1:0][31:0]    iReqArg;
    logic [1:0][1:0]     iReqRespType;
    logic [1:0]          oReqGrant;
    logic [1:0]          oReqDone;
    logic [1:0]          oRespStatus;
    logic [127:0]        oRespData;
    logic                oCmdValid;
    logic [5:0]          oCmdIndex;
    logic [31:0]         oCmdArg;
    logic [1:0]          oCmdExpectResp;
    logic                iCmdAck;
    logic                iRespValid;
    logic                iRespCrcErr;
    logic [127:0]        iRespData;
    logic [2:0]          oDbgState;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_r       = 1;

    sd_cmd_scheduler #(
        .gRespTimeout (TIMEOUT),
        .gNccCycles   (NCC),
        .gMaxRetries  (MAX_RETRIES)
    ) dut (
        .Clk            (Clk),
        .nResetAsync    (nResetAsync),
        .iReqValid      (iReqValid),
        .iReqIndex      (iReqIndex),
        .iReqArg        (iReqArg),
        .iReqRespType   (iReqRespType),
        .oReqGrant      (oReqGrant),
        .oReqDone       (oReqDone),
        .oRespStatus    (oRespStatus),
        .oRespData      (oRespData),
        .oCmdValid      (oCmdValid),
        .oCmdIndex      (oCmdIndex),
        .oCmdArg        (oCmdArg),
        .oCmdExpectResp (oCmdExpectResp),
        .iCmdAck        (iCmdAck),
        .iRespValid     (iRespValid),
        .iRespCrcErr    (iRespCrcErr),
        .iRespData      (iRespData),
        .oDbgState      (oDbgState)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectations derived from the command rules.
    function automatic logic [1:0] model_status(input logic [1:0] typ, input bit give, input bit crc);
        if (typ == 2'd0) return 2'd0;
        if (!give)       return 2'd1;
        return crc ? 2'd2 : 2'd0;
    endfunction

    function automatic logic [127:0] model_data(input logic [1:0] typ, input bit give, input logic [127:0] d);
        if (typ == 2'd0 || !give) return '0;
        if (typ == 2'd2)          return d;
        return {96'd0, d[31:0]};
    endfunction

    task automatic do_cmd(input int r, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] typ, input int ack_dly, input int resp_dly,
                          input bit give, input bit crc, input logic [127:0] rdata);
        int waited;
        int exp_att;
        logic [1:0] exp_gnt;
        logic [1:0] exp_typ;
        exp_gnt      = '0;
        exp_gnt[r]   = 1'b1;
        exp_typ      = (typ == 2'd3) ? 2'd1 : typ;
        exp_att      = (typ != 2'd0 && give && crc && RETRY_EN == 1) ? 1 + MAX_RETRIES : 1;
        @(negedge Clk);
        iReqValid[r]    = 1'b1;
        iReqIndex[r]    = idx;
        iReqArg[r]      = arg;
        iReqRespType[r] = typ;
        waited = 0;
        do begin @(negedge Clk); waited++; end while (oReqGrant == 2'b00 && waited < 40);
        check("grant", oReqGrant, exp_gnt);
        iReqValid[r] = 1'b0;
        last_r = r;
        for (int a = 0; a < exp_att; a++) begin
            check("cmd_valid", oCmdValid, 1'b1);
            check("cmd_index", oCmdIndex, idx);
            check("cmd_arg", oCmdArg, arg);
            check("cmd_type", oCmdExpectResp, exp_typ);
            for (int k = 0; k < ack_dly; k++) begin
                @(negedge Clk);
                check("valid_held", {oCmdValid, oCmdIndex, oCmdArg}, {1'b1, idx, arg});
            end
            iCmdAck = 1'b1;
            @(negedge Clk);
            iCmdAck = 1'b0;
            check("cmd_drop", oCmdValid, 1'b0);
            if (typ != 2'd0) begin
                if (give) begin
                    for (int k = 0; k < resp_dly; k++) begin
                        check("no_early_done", oReqDone, 2'b00);
                        @(negedge Clk);
                    end
                    iRespValid  = 1'b1;
                    iRespCrcErr = crc;
                    iRespData   = rdata;
                    @(negedge Clk);
                    iRespValid  = 1'b0;
                    iRespCrcErr = 1'b0;
                end else begin
                    for (int k = 0; k < TIMEOUT; k++) begin
                        check("no_early_timeout", oReqDone, 2'b00);
                        @(negedge Clk);
                    end
                end
            end
            if (a + 1 < exp_att) begin
                waited = 0;
                while (!oCmdValid && waited < 2 * NCC + 4) begin
                    check("retry_quiet", {oReqDone, oReqGrant}, 4'b0000);
                    @(negedge Clk);
                    waited++;
                end
                check("retry_gap", waited, NCC);
            end
        end
        check("done", oReqDone, exp_gnt);
        check("status", oRespStatus, model_status(typ, give, crc));
        check("data", oRespData, model_data(typ, give, rdata));
        // Strobes arriving outside Issue/WaitResp must be ignored.
        iCmdAck     = 1'b1;
        iRespValid  = 1'b1;
        iRespCrcErr = 1'b1;
        @(negedge Clk);
        iCmdAck     = 1'b0;
        iRespValid  = 1'b0;
        iRespCrcErr = 1'b0;
        check("done_pulse", oReqDone, 2'b00);
        check("no_reissue", oCmdValid, 1'b0);
        check("status_held", oRespStatus, model_status(typ, give, crc));
    endtask

    task automatic rr_burst(input int n);
        int g;
        int prev;
        int waited;
        int exp_r;
        logic [1:0] exp_gnt;
        @(negedge Clk);
        iReqValid    = 2'b11;
        iReqRespType = '0;
        iReqIndex    = {6'd12, 6'd5};
        exp_r = last_r ^ 1;
        g = 0; prev = -1; waited = 0;
        while (g < n && waited < 40 * n) begin
            @(negedge Clk);
            waited++;
            iCmdAck = oCmdValid;
            if (oReqGrant != 2'b00) begin
                exp_gnt        = '0;
                exp_gnt[exp_r] = 1'b1;
                check("rr_grant", oReqGrant, exp_gnt);
                if (prev >= 0) check("rr_spacing", cyc - prev, 3 + NCC);
                prev   = cyc;
                last_r = exp_r;
                exp_r ^= 1;
                g++;
            end
        end
        check("rr_count", g, n);
        iReqValid = 2'b00;
        @(negedge Clk);
        iCmdAck = 1'b0;
    endtask

    initial begin
        int waited;
        nResetAsync  = 1'b0;
        iReqValid    = '0;
        iReqIndex    = '0;
        iReqArg      = '0;
        iReqRespType = '0;
        iCmdAck      = 1'b0;
        iRespValid   = 1'b0;
        iRespCrcErr  = 1'b0;
        iRespData    = '0;
        repeat (2) @(negedge Clk);
        check("rst_outputs", {oReqGrant, oReqDone, oRespStatus, oCmdValid, oCmdIndex,
                              oCmdArg, oCmdExpectResp}, '0);
        check("rst_data", oRespData, '0);
        check("rst_state", oDbgState, S_IDLE);
        nResetAsync = 1'b1;

        do_cmd(0, 6'd0, 32'h0, 2'd0, 2, 0, 1'b0, 1'b0, '0);
        do_cmd(1, 6'd17, 32'h0000_0200, 2'd1, 1, 10, 1'b1, 1'b0,
               {96'hdead_beef_1234_5678_9abc_def0, 32'h0000_0900});
        do_cmd(0, 6'd2, 32'h0, 2'd2, 0, 5, 1'b1, 1'b0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        do_cmd(1, 6'd13, 32'h0001_0000, 2'd1, 0, 0, 1'b0, 1'b0, '0);
        do_cmd(0, 6'd8, 32'h0000_01aa, 2'd1, 0, TIMEOUT - 1, 1'b1, 1'b0, 128'h55);
        do_cmd(1, 6'd55, 32'h0000_1234, 2'd1, 0, 3, 1'b1, 1'b1, 128'h77_0000_0abc);
        do_cmd(0, 6'd41, 32'h4030_0000, 2'd3, 1, 2, 1'b1, 1'b0, {96'h1, 32'h00ff_8000});

        rr_burst(4);

        for (int i = 0; i < 12; i++) begin
            do_cmd(int'($urandom_range(1, 0)), 6'($urandom_range(63, 0)), $urandom(),
                   2'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   ($urandom_range(7, 0) == 0) ? TIMEOUT - 1 : int'($urandom_range(30, 0)),
                   $urandom_range(9, 0) != 0, $urandom_range(4, 0) == 0,
                   {$urandom(), $urandom(), $urandom(), $urandom()});
        end

        do_cmd(1, 6'd2, 32'h0, 2'd2, 0, 4, 1'b1, 1'b0, 128'hffff_0000_1111_2222_3333_4444_5555_6666);

        // Reset while waiting for a response.
        @(negedge Clk);
        iReqValid[0]    = 1'b1;
        iReqIndex[0]    = 6'd9;
        iReqArg[0]      = 32'h0000_cafe;
        iReqRespType[0] = 2'd1;
        waited = 0;
        do begin @(negedge Clk); waited++; end while (oReqGrant == 2'b00 && waited < 40);
        check("rst_pre_grant", oReqGrant, 2'b01);
        iReqValid = 2'b00;
        iCmdAck   = 1'b1;
        @(negedge Clk);
        iCmdAck = 1'b0;
        repeat (5) @(negedge Clk);
        check("rst_in_wait", oDbgState, S_WAIT_RESP);
        nResetAsync = 1'b0;
        #1;
        check("rst_mid_outputs", {oReqGrant, oReqDone, oRespStatus, oCmdValid, oCmdIndex,
                                  oCmdArg, oCmdExpectResp}, '0);
        check("rst_mid_data", oRespData, '0);
        @(negedge Clk);
        nResetAsync = 1'b1;
        last_r = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("rst_no_done", oReqDone, 2'b00);
        end
        rr_burst(2);
        do_cmd(1, 6'd7, 32'h0000_0abc, 2'd1, 0, 6, 1'b1, 1'b0, 128'h1_0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sd_cmd_scheduler.md
Name: sd_cmd_scheduler

Overview:
- Arbitrates two command requesters for the single SD command path: requester 0 is the card-init FSM, requester 1 is the data-transfer controller.
- Sequences one command at a time through the SdCmd entity: issue, wait for response with timeout, report result, then enforce the inter-command gap (Ncc).
- Sits between the SD controller FSMs and SdCmd; never touches the Cmd/Data wires directly.

Parameters:
- gRespTimeout, 64, Clk cycles allowed from command ack to response before timeout (Ncr limit).
- gNccCycles, 8, idle Clk cycles enforced after each completed command.
- gMaxRetries, 2, retries on CRC error (used only with SD_CMD_RETRY_EN).

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- nResetAsync  in  1  asynchronous active-low reset.
- iReqValid  in  2  per-requester command request (bit n = requester n).
- iReqIndex  in  2x6  command index per requester.
- iReqArg  in  2x32  command argument per requester.
- iReqRespType  in  2x2  0 none, 1 R1/R3/R6/R7 (48-bit), 2 R2 (136-bit), 3 reserved (treated as 1).
- oReqGrant  out  2  one-cycle pulse: request latched.
- oReqDone  out  2  one-cycle pulse to the granted requester: result valid.
- oRespStatus  out  2  0 ok, 1 timeout, 2 crc error; held until the next done.
- oRespData  out  128  response payload (R1: bits 31:0, upper bits zero); held until the next done.
- oCmdValid  out  1  command to SdCmd valid.
- oCmdIndex  out  6  latched command index.
- oCmdArg  out  32  latched argument.
- oCmdExpectResp  out  2  latched response type.
- iCmdAck  in  1  SdCmd finished shifting out the command.
- iRespValid  in  1  SdCmd received a complete response.
- iRespCrcErr  in  1  qualifies iRespValid.
- iRespData  in  128  received payload.

Behaviour:
- Reset: all outputs 0, FSM Idle, round-robin pointer on requester 0, counters 0.
- States: Idle -> Issue -> WaitResp -> Complete -> Gap -> Idle.
- Idle:
  - Any iReqValid bit set: select the requester per round-robin (pointer favours the requester not served last).
  - Latch index, arg and resp type; pulse oReqGrant[sel]; go to Issue on the next cycle.
  - The pointer advances only on grant.
- Issue:
  - oCmdValid=1 and the cmd fields stay stable until iCmdAck.
  - On ack, drop oCmdValid in the next cycle.
  - Resp type 0: go to Complete with status ok, data 0.
  - Otherwise go to WaitResp and clear the timeout counter.
- WaitResp:
  - Counter increments each cycle.
  - iRespValid: capture data and CRC flag, go to Complete.
  - Counter reaches gRespTimeout-1 with no response: status timeout, go to Complete.
  - iRespValid in the same cycle as expiry: response wins.
- Complete: one cycle; oReqDone[sel]=1, oRespStatus/oRespData updated the same cycle. Go to Gap.
- Gap:
  - Counts gNccCycles cycles, then Idle.
  - Requests arriving during Gap stay pending; they are not granted early.
- Requester may drop iReqValid after grant without effect; a request is considered only in Idle.
- iRespValid outside WaitResp is ignored. iCmdAck outside Issue is ignored.
- Reset asserted mid-operation: immediate return to the reset state; no done pulse.
- Latency, ack to done: 1 cycle for type 0; response-valid cycle +1 otherwise.
- Minimum grant-to-grant spacing: 3 + gNccCycles cycles.

Optional Feature:
- Macro: SD_CMD_RETRY_EN.
- Defined:
  - A CRC error in WaitResp with retry count < gMaxRetries increments the count, passes through Gap, then re-enters Issue with the same latched command.
  - No done pulse and no new grant occur until the final outcome.
  - Count clears on grant.
  - Timeouts are never retried.
- Undefined: a CRC error completes immediately with status 2; gMaxRetries is unused.

Decomposition:
- Package sd_cmd_pkg holds:
  - resp-type enum (none, r48, r136);
  - status enum (ok, timeout, crcerr);
  - FSM state enum;
  - command index width 6, argument width 32, response width 128.
- One natural sub-module, sd_rr_arbiter2: 2-way round-robin with a grant-advance input, reused later for the data-line scheduler.

Test Plan:
- Req0 idx 0 arg 0 type none -> grant0, oCmdValid until ack, done0 1 cycle after ack, status ok, data 0.
- Req1 idx 17 arg 0x0000_0200 type R1, response 0x0000_0900 after 10 cycles -> done1, status ok, oRespData=0x900.
- Both valid continuously -> grants alternate 0,1,0,1; each grant at least 3+8 cycles after the previous.
- Type R1, no iRespValid -> done after 64 cycles in WaitResp, status timeout; iRespValid on the expiry cycle -> status ok instead.
- CRC error response: without macro -> status crcerr; with macro -> 2 re-issues of the same idx/arg, then crcerr on the third.
- nResetAsync pulsed during WaitResp -> outputs 0 immediately, no done, next request granted normally.
